// File: rtl/gpio_mmio_bank.sv
// Memory-mapped GPIO bank: NUM_PORTS 8-bit ports with output/OE, synchronised
// inputs, sticky W1C edge flags and a combined level interrupt on the IO bus.
module gpio_mmio_bank #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned BASE_ADDR  = 'h080,
    parameter int unsigned NUM_PORTS  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   dmem_addr,
    input  logic                    dmem_wen,
    input  logic                    dmem_byt,
    input  logic [15:0]             dmem_wdata,
    output logic [15:0]             dmem_rdata,
    input  logic [8*NUM_PORTS-1:0]  gpio_in,
    output logic [8*NUM_PORTS-1:0]  gpio_out,
    output logic [8*NUM_PORTS-1:0]  gpio_oe,
    output logic                    irq
);

    localparam int unsigned PW = 8 * NUM_PORTS;
    // BASE_ADDR is 8-byte aligned, so the port index needs only address bits [5:3]
    localparam logic [2:0] BASE_PSEL = 3'(BASE_ADDR >> 3);

    typedef enum logic [1:0] {
        REG_CTRL = 2'd0,
        REG_IN   = 2'd1,
        REG_STAT = 2'd2,
        REG_EDGE = 2'd3
    } reg_e;

    logic [7:0] out_q     [NUM_PORTS];
    logic [7:0] oe_q      [NUM_PORTS];
    logic [7:0] ie_q      [NUM_PORTS];
    logic [7:0] flag_q    [NUM_PORTS];
    logic [7:0] rise_en_q [NUM_PORTS];
    logic [7:0] fall_en_q [NUM_PORTS];

    logic [PW-1:0] sync1_q, sync2_q, prev_q;
    logic [PW-1:0] rise, fall;

    logic                 in_win;
    logic [2:0]           port_sel;
    reg_e                 reg_sel;
    logic [NUM_PORTS-1:0] port_hit;
    logic                 wr_lo, wr_hi;
    logic [7:0]           lo_data, hi_data;
    logic [7:0]           set_v [NUM_PORTS];
    logic [7:0]           clr_v [NUM_PORTS];
    logic [15:0]          rd_word;
    logic                 irq_next;

    always_comb begin
        in_win   = (32'(dmem_addr) >= BASE_ADDR) &&
                   (32'(dmem_addr) <  BASE_ADDR + 8 * NUM_PORTS);
        port_sel = dmem_addr[5:3] - BASE_PSEL;
        reg_sel  = reg_e'(dmem_addr[2:1]);
        port_hit = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            port_hit[i] = in_win && (32'(port_sel) == i);
        end
        // Word access writes both bytes; byte access steers wdata[7:0] by addr[0]
        wr_lo   = dmem_wen && (!dmem_byt || !dmem_addr[0]);
        wr_hi   = dmem_wen && (!dmem_byt ||  dmem_addr[0]);
        lo_data = dmem_wdata[7:0];
        hi_data = dmem_byt ? dmem_wdata[7:0] : dmem_wdata[15:8];
    end

    always_comb begin
        rise = sync2_q & ~prev_q;
        fall = ~sync2_q & prev_q;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            set_v[i] = (rise[8*i +: 8] & rise_en_q[i]) | (fall[8*i +: 8] & fall_en_q[i]);
            clr_v[i] = (port_hit[i] && wr_lo && reg_sel == REG_STAT) ? lo_data : '0;
        end
    end

    always_comb begin
        rd_word  = '0;
        irq_next = 1'b0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            irq_next = irq_next | (|(flag_q[i] & ie_q[i]));
            if (port_hit[i]) begin
                case (reg_sel)
                    REG_CTRL: rd_word = {oe_q[i], out_q[i]};
                    REG_IN:   rd_word = {8'h00, sync2_q[8*i +: 8]};
                    REG_STAT: rd_word = {ie_q[i], flag_q[i]};
                    REG_EDGE: rd_word = {fall_en_q[i], rise_en_q[i]};
                    default:  rd_word = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            dmem_rdata <= '0;
            irq        <= 1'b0;
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                out_q[i]     <= '0;
                oe_q[i]      <= '0;
                ie_q[i]      <= '0;
                flag_q[i]    <= '0;
                rise_en_q[i] <= '0;
                fall_en_q[i] <= '0;
            end
        end else begin
            sync1_q    <= gpio_in;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            dmem_rdata <= rd_word;
            irq        <= irq_next;
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                // A same-cycle edge beats a W1C clear of the same bit
                flag_q[i] <= (flag_q[i] & ~clr_v[i]) | set_v[i];
                if (port_hit[i] && wr_lo) begin
                    case (reg_sel)
                        REG_CTRL: out_q[i]     <= lo_data;
                        REG_EDGE: rise_en_q[i] <= lo_data;
                        default: ;
                    endcase
                end
                if (port_hit[i] && wr_hi) begin
                    case (reg_sel)
                        REG_CTRL: oe_q[i]      <= hi_data;
                        REG_STAT: ie_q[i]      <= hi_data;
                        REG_EDGE: fall_en_q[i] <= hi_data;
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        gpio_out = '0;
        gpio_oe  = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            gpio_out[8*i +: 8] = out_q[i];
            gpio_oe[8*i +: 8]  = oe_q[i];
        end
    end

endmodule

// File: tb/tb_gpio_mmio_bank.sv
// Bench for gpio_mmio_bank: vector table, edge/W1C/reset sequences, then
// randomized traffic against a register-map model with a pin-history queue.
module tb_gpio_mmio_bank;

    localparam int NP   = 2;
    localparam int BASE = 'h080;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] dmem_addr;
    logic        dmem_wen;
    logic        dmem_byt;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata;
    logic [15:0] gpio_in;
    logic [15:0] gpio_out;
    logic [15:0] gpio_oe;
    logic        irq;

    always #5 clk = ~clk;

    gpio_mmio_bank #(
        .ADDR_WIDTH(16),
        .BASE_ADDR (BASE),
        .NUM_PORTS (NP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dmem_addr (dmem_addr),
        .dmem_wen  (dmem_wen),
        .dmem_byt  (dmem_byt),
        .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .gpio_oe   (gpio_oe),
        .irq       (irq)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: register map as arrays, pins as a history of edge samples
    logic [7:0]  m_out [NP], m_oe [NP], m_ie [NP], m_flag [NP], m_re [NP], m_fe [NP];
    logic [15:0] pin_q [$];   // [0] = pins sampled last edge, [1] two edges ago, ...
    logic [15:0] m_rdata;
    logic        m_irq;

    task automatic model_step();
        int a, p, r;
        bit inwin, lo_we, hi_we;
        logic [7:0] lo, hi, set, clr, cur, old;
        logic [15:0] in_now, in_old;
        if (rst) begin
            for (int i = 0; i < NP; i++) begin
                m_out[i] = 0; m_oe[i] = 0; m_ie[i] = 0;
                m_flag[i] = 0; m_re[i] = 0; m_fe[i] = 0;
            end
            m_rdata = 0;
            m_irq   = 0;
            pin_q.delete();
            repeat (3) pin_q.push_back(16'h0);
            return;
        end
        in_now = pin_q[1];   // visible IN value
        in_old = pin_q[2];   // IN value one cycle earlier
        a = int'(dmem_addr);
        inwin = (a >= BASE) && (a < BASE + 8 * NP);
        p = (a - BASE) / 8;
        r = ((a - BASE) % 8) / 2;
        m_rdata = 0;
        if (inwin) begin
            case (r)
                0: m_rdata = {m_oe[p], m_out[p]};
                1: m_rdata = {8'h00, in_now[8*p +: 8]};
                2: m_rdata = {m_ie[p], m_flag[p]};
                default: m_rdata = {m_fe[p], m_re[p]};
            endcase
        end
        m_irq = 0;
        for (int i = 0; i < NP; i++) if ((m_flag[i] & m_ie[i]) != 0) m_irq = 1;
        lo_we = dmem_wen && inwin && (!dmem_byt || (a % 2 == 0));
        hi_we = dmem_wen && inwin && (!dmem_byt || (a % 2 == 1));
        lo = dmem_wdata[7:0];
        hi = dmem_byt ? dmem_wdata[7:0] : dmem_wdata[15:8];
        for (int i = 0; i < NP; i++) begin
            cur = in_now[8*i +: 8];
            old = in_old[8*i +: 8];
            set = (cur & ~old & m_re[i]) | (~cur & old & m_fe[i]);
            clr = (lo_we && i == p && r == 2) ? lo : 8'h00;
            m_flag[i] = (m_flag[i] & ~clr) | set;
        end
        if (lo_we) begin
            if (r == 0) m_out[p] = lo;
            if (r == 3) m_re[p]  = lo;
        end
        if (hi_we) begin
            if (r == 0) m_oe[p] = hi;
            if (r == 2) m_ie[p] = hi;
            if (r == 3) m_fe[p] = hi;
        end
        pin_q.push_front(gpio_in);
        void'(pin_q.pop_back());
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic bus(input logic [15:0] a, input logic w, input logic b, input logic [15:0] d);
        dmem_addr  = a;
        dmem_wen   = w;
        dmem_byt   = b;
        dmem_wdata = d;
    endtask

    typedef struct {
        string       name;
        logic        rst;
        logic [15:0] addr;
        logic        wen;
        logic        byt;
        logic [15:0] wdata;
        logic [15:0] e_out;
        logic [15:0] e_oe;
        logic [15:0] e_rdata;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t v(input string n, input logic r, input logic [15:0] a,
                               input logic w, input logic b, input logic [15:0] d,
                               input logic [15:0] eo, input logic [15:0] ee,
                               input logic [15:0] er);
        vec_t x;
        x.name = n; x.rst = r; x.addr = a; x.wen = w; x.byt = b; x.wdata = d;
        x.e_out = eo; x.e_oe = ee; x.e_rdata = er;
        return x;
    endfunction

    task automatic expect_rd(input string n, input logic [15:0] a, input logic [15:0] exp);
        bus(a, 1'b0, 1'b0, 16'h0);
        tick();
        check(n, dmem_rdata, exp);
    endtask

    initial begin
        rst = 1'b1;
        gpio_in = 16'h0;
        bus(16'h080, 1'b0, 1'b0, 16'h0);

        tbl.push_back(v("reset",        1, 16'h080, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
        tbl.push_back(v("wword_080",    0, 16'h080, 1, 0, 16'hF0A5, 16'h00A5, 16'h00F0, 16'h0000));
        tbl.push_back(v("rd_080",       0, 16'h080, 0, 0, 16'h0000, 16'h00A5, 16'h00F0, 16'hF0A5));
        tbl.push_back(v("wbyte_089",    0, 16'h089, 1, 1, 16'hAA3C, 16'h00A5, 16'h3CF0, 16'h0000));
        tbl.push_back(v("rd_088",       0, 16'h088, 0, 0, 16'h0000, 16'h00A5, 16'h3CF0, 16'h3C00));
        tbl.push_back(v("wbyte_in_08A", 0, 16'h08A, 1, 1, 16'h00FF, 16'h00A5, 16'h3CF0, 16'h0000));
        tbl.push_back(v("wword_in_08A", 0, 16'h08A, 1, 0, 16'hFFFF, 16'h00A5, 16'h3CF0, 16'h0000));
        tbl.push_back(v("rd_088_again", 0, 16'h088, 0, 0, 16'h0000, 16'h00A5, 16'h3CF0, 16'h3C00));
        tbl.push_back(v("rd_090_out",   0, 16'h090, 0, 0, 16'h0000, 16'h00A5, 16'h3CF0, 16'h0000));
        tbl.push_back(v("wword_07E",    0, 16'h07E, 1, 0, 16'hFFFF, 16'h00A5, 16'h3CF0, 16'h0000));
        tbl.push_back(v("rd_086",       0, 16'h086, 0, 0, 16'h0000, 16'h00A5, 16'h3CF0, 16'h0000));
        tbl.push_back(v("rd_080_again", 0, 16'h080, 0, 0, 16'h0000, 16'h00A5, 16'h3CF0, 16'hF0A5));
        tbl.push_back(v("wbyte_088",    0, 16'h088, 1, 1, 16'h0077, 16'h77A5, 16'h3CF0, 16'h3C00));
        tbl.push_back(v("wword_081",    0, 16'h081, 1, 0, 16'h1234, 16'h7734, 16'h3C12, 16'hF0A5));
        tbl.push_back(v("rd_081",       0, 16'h081, 0, 0, 16'h0000, 16'h7734, 16'h3C12, 16'h1234));
        tbl.push_back(v("rd_089",       0, 16'h089, 0, 0, 16'h0000, 16'h7734, 16'h3C12, 16'h3C77));
        tbl.push_back(v("wword_09E",    0, 16'h09E, 1, 0, 16'hFFFF, 16'h7734, 16'h3C12, 16'h0000));
        tbl.push_back(v("wword_08E",    0, 16'h08E, 1, 0, 16'h5AA5, 16'h7734, 16'h3C12, 16'h0000));
        tbl.push_back(v("rd_08F",       0, 16'h08F, 0, 0, 16'h0000, 16'h7734, 16'h3C12, 16'h5AA5));
        tbl.push_back(v("wbyte_08F",    0, 16'h08F, 1, 1, 16'h00C3, 16'h7734, 16'h3C12, 16'h5AA5));
        tbl.push_back(v("rd_08E",       0, 16'h08E, 0, 0, 16'h0000, 16'h7734, 16'h3C12, 16'hC3A5));

        foreach (tbl[i]) begin
            rst = tbl[i].rst;
            bus(tbl[i].addr, tbl[i].wen, tbl[i].byt, tbl[i].wdata);
            tick();
            check({tbl[i].name, ".out"},   gpio_out,   tbl[i].e_out);
            check({tbl[i].name, ".oe"},    gpio_oe,    tbl[i].e_oe);
            check({tbl[i].name, ".rdata"}, dmem_rdata, tbl[i].e_rdata);
            check({tbl[i].name, ".irq"},   irq,        1'b0);
        end

        // Rising edge timing: RISE_EN0=01, IE0=01, pin change captured at edge k
        bus(16'h086, 1'b1, 1'b0, 16'h0001); tick();
        bus(16'h084, 1'b1, 1'b0, 16'h0100); tick();
        bus(16'h082, 1'b0, 1'b0, 16'h0000);
        gpio_in = 16'h0001;
        tick(); check("edge_k.in",    dmem_rdata, 16'h0000); check("edge_k.irq",  irq, 1'b0);
        tick(); check("edge_k1.in",   dmem_rdata, 16'h0000); check("edge_k1.irq", irq, 1'b0);
        tick(); check("edge_k2.in",   dmem_rdata, 16'h0001); check("edge_k2.irq", irq, 1'b0);
        bus(16'h084, 1'b0, 1'b0, 16'h0000);
        tick(); check("edge_k3.stat", dmem_rdata, 16'h0101); check("edge_k3.irq", irq, 1'b1);

        // W1C by byte write keeps IE; irq drops one cycle after the flag
        bus(16'h084, 1'b1, 1'b1, 16'h0001);
        tick(); check("w1c.irq_hold", irq, 1'b1);
        bus(16'h084, 1'b0, 1'b0, 16'h0000);
        tick(); check("w1c.stat", dmem_rdata, 16'h0100); check("w1c.irq_low", irq, 1'b0);

        // Falling edge with FALL_EN=0 must not flag
        gpio_in = 16'h0000;
        repeat (5) tick();
        check("fall_noflag.stat", dmem_rdata, 16'h0100);
        check("fall_noflag.irq",  irq, 1'b0);

        // Re-arm the flag, drop the pin, then land a new rise on the same edge as a W1C
        gpio_in = 16'h0001; repeat (5) tick();
        check("rearm.irq", irq, 1'b1);
        gpio_in = 16'h0000; repeat (5) tick();
        gpio_in = 16'h0001;
        tick();
        tick();
        bus(16'h084, 1'b1, 1'b1, 16'h0001);
        tick();
        bus(16'h084, 1'b0, 1'b0, 16'h0000);
        tick();
        check("setwins.stat", dmem_rdata, 16'h0101);
        check("setwins.irq",  irq, 1'b1);

        // Reset with live state, a simultaneous write and all pins high
        check("pre_rst.irq", irq, 1'b1);
        rst = 1'b1;
        gpio_in = 16'hFFFF;
        bus(16'h080, 1'b1, 1'b0, 16'hFFFF);
        tick();
        check("rst.out",   gpio_out,   16'h0000);
        check("rst.oe",    gpio_oe,    16'h0000);
        check("rst.rdata", dmem_rdata, 16'h0000);
        check("rst.irq",   irq,        1'b0);
        rst = 1'b0;
        bus(16'h084, 1'b0, 1'b0, 16'h0000);
        repeat (4) tick();
        check("post_rst.irq", irq, 1'b0);
        expect_rd("post_rst.stat0", 16'h084, 16'h0000);
        expect_rd("post_rst.stat1", 16'h08C, 16'h0000);
        expect_rd("post_rst.ctrl0", 16'h080, 16'h0000);
        expect_rd("post_rst.edge1", 16'h08E, 16'h0000);
        expect_rd("post_rst.in0",   16'h082, 16'h00FF);
        expect_rd("post_rst.in1",   16'h08A, 16'h00FF);
        check("post_rst.out", gpio_out, 16'h0000);

        // Randomized traffic against the model
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            bus(16'(BASE - 8 + int'($urandom_range(0, 39))),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
            if ($urandom_range(0, 3) == 0)
                gpio_in = gpio_in ^ (16'h1 << $urandom_range(0, 15));
            tick();
            check($sformatf("rnd%0d.rdata", c), dmem_rdata, m_rdata);
            check($sformatf("rnd%0d.irq", c),   irq,        m_irq);
            check($sformatf("rnd%0d.out", c),   gpio_out,   {m_out[1], m_out[0]});
            check($sformatf("rnd%0d.oe", c),    gpio_oe,    {m_oe[1], m_oe[0]});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
